processor_sequencer: RTL

//  Multi-cycle control unit for the 8-bit accumulator processor. It owns the program

---
 rtl/processor_sequencer_pkg.sv | 45 ++++
 rtl/processor_sequencer_seq_enable_decode.sv | 28 ++
 rtl/processor_sequencer.sv | 96 +++++++++
 3 files changed

// File: rtl/processor_sequencer_pkg.sv
// Shared definitions for the accumulator-processor sequencer: instruction
// field widths, opcode values, sequencer state encodings and the enable bundle.
package processor_sequencer_pkg;

   localparam int PC_WIDTH = 5;
   localparam int OPCODE_W = 4;
   localparam int ARG_W    = 5;   // must be >= PC_WIDTH so a jump target fits in the argument
   localparam int INSTR_W  = OPCODE_W + ARG_W;

   // Opcode values (instruction MSBs)
   localparam logic [OPCODE_W-1:0] OP_NOP = 4'h0;
   localparam logic [OPCODE_W-1:0] OP_LD  = 4'h1;
   localparam logic [OPCODE_W-1:0] OP_ST  = 4'h2;
   localparam logic [OPCODE_W-1:0] OP_ADD = 4'h3;
   localparam logic [OPCODE_W-1:0] OP_SUB = 4'h4;
   localparam logic [OPCODE_W-1:0] OP_AND = 4'h5;
   localparam logic [OPCODE_W-1:0] OP_OR  = 4'h6;
   localparam logic [OPCODE_W-1:0] OP_XOR = 4'h7;
   localparam logic [OPCODE_W-1:0] OP_NOT = 4'h8;
   localparam logic [OPCODE_W-1:0] OP_JMP = 4'h9;
   localparam logic [OPCODE_W-1:0] OP_JZ  = 4'hA;
   localparam logic [OPCODE_W-1:0] OP_HLT = 4'hB;

   // Sequencer state encodings
   localparam logic [2:0] SEQ_IDLE   = 3'd0;
   localparam logic [2:0] SEQ_FETCH  = 3'd1;
   localparam logic [2:0] SEQ_DECODE = 3'd2;
   localparam logic [2:0] SEQ_EXEC   = 3'd3;
   localparam logic [2:0] SEQ_HALT   = 3'd4;

   // One-cycle datapath enables issued during EXEC
   typedef struct packed {
      logic ld;    // register file -> accumulator path
      logic st;    // accumulator -> register file
      logic acc;   // accumulator write
      logic cy;    // carry flag write
   } seq_en_t;

   // True for opcodes that run through the ALU and update accumulator and carry
   function automatic logic is_alu_op(input logic [OPCODE_W-1:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
             (op == OP_OR)  || (op == OP_XOR) || (op == OP_NOT);
   endfunction

endpackage

// File: rtl/processor_sequencer_seq_enable_decode.sv
// Combinational decode of the instruction-register opcode into the
// register-file / ALU enables. Enables are only ever raised while executing.
module seq_enable_decode
   import processor_sequencer_pkg::*;
(
   input  logic                i_exec,
   input  logic [OPCODE_W-1:0] i_opcode,
   output seq_en_t             o_en
);

   // Map the opcode to its enable set, gated by the execute qualifier
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (avoids a latch).
      o_en = '0;
      if (i_exec) begin
         if (i_opcode == OP_LD) begin
            o_en.ld  = 1'b1;
            o_en.acc = 1'b1;
         end else if (i_opcode == OP_ST) begin
            o_en.st  = 1'b1;
         end else if (is_alu_op(i_opcode)) begin
            o_en.acc = 1'b1;
            o_en.cy  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/processor_sequencer.sv
// Multi-cycle control unit for the 8-bit accumulator processor. Owns the PC and
// IR, walks each instruction through FETCH -> DECODE -> EXEC, supports JMP/JZ/HLT
// and run / single-step debug control.
module processor_sequencer
   import processor_sequencer_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                run,
   input  logic                step,
   input  logic [INSTR_W-1:0]  instr,
   input  logic                acc_zero,
   output logic [PC_WIDTH-1:0] pc,
   output logic [OPCODE_W-1:0] opcode,
   output logic [ARG_W-1:0]    reg_addr,
   output logic                ld_ce,
   output logic                st_ce,
   output logic                acc_ce,
   output logic                cy_ce,
   output logic                halted,
   output logic                step_done
);

   logic [2:0]          r_state;
   logic [PC_WIDTH-1:0] r_pc;
   logic [INSTR_W-1:0]  r_ir;
   logic                r_single_step;

   logic [2:0]          w_next_state;
   logic [PC_WIDTH-1:0] w_pc_next;
   logic [OPCODE_W-1:0] w_op;
   logic [ARG_W-1:0]    w_arg;
   logic                w_take_jump;
   logic                w_exec_live;
   seq_en_t             w_en;

   assign w_op  = r_ir[INSTR_W-1 -: OPCODE_W];
   assign w_arg = r_ir[ARG_W-1:0];

   // A reset arriving during EXEC must suppress that cycle's enables so the
   // datapath is not disturbed by the instruction being abandoned.
   assign w_exec_live = (r_state == SEQ_EXEC) && !rst;

   // Next-state selection for the instruction walk and debug control
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         SEQ_IDLE:   if (run || step) w_next_state = SEQ_FETCH;
         SEQ_FETCH:  w_next_state = SEQ_DECODE;
         SEQ_DECODE: w_next_state = (w_op == OP_HLT) ? SEQ_HALT : SEQ_EXEC;
         SEQ_EXEC:   w_next_state = (run && !r_single_step) ? SEQ_FETCH : SEQ_IDLE;
         SEQ_HALT:   w_next_state = SEQ_HALT;
         default:    w_next_state = SEQ_IDLE;
      endcase
   end

   // Program-counter successor: jump target or sequential increment (wraps naturally)
   always_comb begin
      w_take_jump = (w_op == OP_JMP) || ((w_op == OP_JZ) && acc_zero);
      w_pc_next   = w_take_jump ? w_arg[PC_WIDTH-1:0] : r_pc + PC_WIDTH'(1);
   end

   // State, PC, IR and single-step mode registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         r_state       <= SEQ_IDLE;
         r_pc          <= '0;
         r_ir          <= '0;
         r_single_step <= 1'b0;
      end else begin
         r_state <= w_next_state;
         // run has priority: a step seen together with run is not single-step mode
         if (r_state == SEQ_IDLE)  r_single_step <= step && !run;
         if (r_state == SEQ_FETCH) r_ir          <= instr;
         if (r_state == SEQ_EXEC)  r_pc          <= w_pc_next;
      end
   end

   seq_enable_decode u_enable_decode (
      .i_exec   (w_exec_live),
      .i_opcode (w_op),
      .o_en     (w_en)
   );

   assign pc        = r_pc;
   assign opcode    = w_op;
   assign reg_addr  = w_arg;
   assign ld_ce     = w_en.ld;
   assign st_ce     = w_en.st;
   assign acc_ce    = w_en.acc;
   assign cy_ce     = w_en.cy;
   assign halted    = (r_state == SEQ_HALT);
   assign step_done = w_exec_live && r_single_step;

endmodule
